ws_systolic_tile: RTL
=====================

// Module: ws_systolic_tile
// PURPOSE
//  Parametrised weight-stationary systolic matrix-vector tile, successor to the fixed 4x4 MMU.
//  Holds a ROWS x COLS weight matrix W and computes y[c] = sum_r x[r]*W[r][c] per input vector.
//  Adds valid/ready handshakes, internal input skew and output deskew, and a load/drain FSM.
//  Sits between the activation/weight SRAM readers and the accumulator bank.
// PARAMETERS
//  DATA_W  8   activation/weight width
//  ACC_W   16  partial-sum/output width (>= 2*DATA_W)
//  ROWS    4   input-vector length = PE rows
//  COLS    4   output-vector length = PE columns
//  SIGNED  0   1: two's-complement operands, 0: unsigned
// PORTS
//  clk        in   1             clock, all state on posedge
//  reset      in   1             synchronous, active-high
//  wt_valid   in   1             weight row beat valid
//  wt_ready   out  1             tile accepts weight beat
//  wt_row     in   COLS*DATA_W   W[row_cnt][c] at bits [c*DATA_W +: DATA_W]
//  act_valid  in   1             activation vector valid
//  act_ready  out  1             tile accepts activation vector
//  act_vec    in   ROWS*DATA_W   x[r] at [r*DATA_W +: DATA_W], unskewed
//  out_valid  out  1             out_vec holds a complete result vector
//  out_vec    out  COLS*ACC_W    y[c] at [c*ACC_W +: ACC_W], deskewed
//  out_ovf    out  COLS          per-column overflow flag (see CONFIGURATION)
//  busy       out  1             state != READY or in-flight count != 0
// BEHAVIOUR
//  Reset: all outputs 0, weights and pipelines cleared, state EMPTY, row_cnt 0, inflight 0.
//    Reset mid-operation discards all in-flight vectors; no out_valid follows.
//  FSM: EMPTY -> LOAD -> READY -> (DRAIN ->) LOAD.
//    EMPTY: wt_ready=1; accepted beat writes row 0 -> LOAD, row_cnt=1.
//    LOAD: wt_ready=1; each accepted beat writes row row_cnt, row_cnt++;
//      beat with row_cnt==ROWS-1 -> READY, row_cnt=0. Idle cycles allowed.
//    READY: act_ready = !wt_valid (weights win simultaneous requests).
//      wt_valid && inflight==0: beat accepted as row 0 -> LOAD.
//      wt_valid && inflight!=0: -> DRAIN, beat not accepted.
//    DRAIN: wt_ready=0, act_ready=0; inflight==0 -> LOAD (row_cnt=0).
//  Transfer = valid && ready on a posedge. One vector per cycle at full throughput.
//  Dataflow: x[r] delayed r cycles, then moves right one PE/cycle along row r;
//    psums move down one PE/cycle; column c output delayed COLS-1-c cycles.
//  Latency L = ROWS+COLS-1: vector accepted at edge k -> out_valid high after edge k+L (4x4: 7).
//  No output backpressure: out_valid is a 1-cycle pulse per vector; sink must accept it.
//  inflight (0..L): +1 on act accept, -1 on out_valid, unchanged when both occur.
//  Arithmetic: product 2*DATA_W, sign-/zero-extended per SIGNED to ACC_W.
//    Accumulation wraps modulo 2^ACC_W unless WS_SAT_EN.
//  Weights are never updated while inflight!=0; results always use one consistent W.
// CONFIGURATION
//  WS_SAT_EN defined: each PE add saturates to the ACC_W max/min for SIGNED.
//    out_ovf[c]=1 with out_valid if any add in column c saturated for that vector
//    (flag travels with the psum).
//  WS_SAT_EN undefined: wrap-around arithmetic; out_ovf tied to 0.
// STRUCTURE
//  Package ws_sa_pkg: state enum (EMPTY, LOAD, READY, DRAIN), function ws_latency(ROWS,COLS),
//    extend/saturate helper functions parametrised on SIGNED.
//  Sub-module ws_pe: weight register with load enable, activation pass register,
//    MAC plus psum register, ovf pass bit. Instantiated ROWS*COLS in a generate grid.
//  Skew/deskew shift registers and FSM live in the top module.
// TESTING (4x4, DATA_W=8, ACC_W=16)
//  1 Load rows {4,3,2,5},{3,2,1,3},{2,1,4,7},{3,4,2,1}; x={1,1,1,1}
//    -> y={12,10,9,16} exactly 7 cycles after accept.
//  2 Back-to-back x={1,2,0,0} then {1,1,1,1} -> y={10,7,4,11} then {12,10,9,16}
//    on consecutive cycles; inflight returns to 0.
//  3 wt_valid asserted with 3 vectors in flight -> DRAIN, act_ready=0, all 3 results emitted
//    from old W, then reload accepted; new results use new W.
//  4 All W=255, x=255, unsigned -> WS_SAT_EN: y=0xFFFF, out_ovf=4'hF;
//    without it: y=0xF804, out_ovf=0.
//  5 SIGNED=1, all W=8'hFF, x={2,3,0,0} -> y[c]=16'hFFFB for every column.
//  6 reset pulse with vectors in flight -> no out_valid afterwards, state EMPTY, wt_ready=1,
//    act_ready=0.

Source files
------------

// File: rtl/ws_sa_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary systolic tile.
package ws_sa_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } ws_state_t;

  // Cycles from activation accept to out_valid.
  function automatic int unsigned ws_latency(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

  // Overflow of a+b from operand/sum MSBs and carry-out; unsigned adds only overflow upward.
  function automatic logic ws_add_ovf(input logic a_msb, input logic b_msb, input logic s_msb,
                                      input logic carry, input logic sgn);
    return sgn ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
  endfunction

  // Saturation direction: toward max unless a signed add of negatives overflowed.
  function automatic logic ws_sat_hi(input logic a_msb, input logic sgn);
    return !sgn || !a_msb;
  endfunction

endpackage

// File: rtl/ws_pe.sv
// Weight-stationary processing element: held weight, activation pass-through, MAC into psum.
// WS_SAT_EN selects saturating accumulation with an overflow flag that travels with the psum.
module ws_pe
  import ws_sa_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wt_load,
  input  logic [DATA_W-1:0] wt_in,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              ovf_in,
  output logic [DATA_W-1:0] act_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              ovf_out
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] wt;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              ovf_nxt;

  // Product extended to accumulator width according to operand signedness.
  if (SIGNED != 0) begin : g_sgn
    logic signed [PROD_W-1:0] prod;
    assign prod     = PROD_W'($signed(act_in)) * PROD_W'($signed(wt));
    assign prod_ext = ACC_W'(prod);
  end else begin : g_uns
    logic [PROD_W-1:0] prod;
    assign prod     = PROD_W'(act_in) * PROD_W'(wt);
    assign prod_ext = ACC_W'(prod);
  end

`ifdef WS_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

  logic [ACC_W:0] sum_full;
  logic           add_ovf;

  assign sum_full = {1'b0, psum_in} + {1'b0, prod_ext};
  assign add_ovf  = ws_add_ovf(psum_in[ACC_W-1], prod_ext[ACC_W-1], sum_full[ACC_W-1],
                               sum_full[ACC_W], SIGNED != 0);

  always_comb begin
    sum = sum_full[ACC_W-1:0];
    if (add_ovf) sum = ws_sat_hi(psum_in[ACC_W-1], SIGNED != 0) ? ACC_MAX : ACC_MIN;
  end

  assign ovf_nxt = ovf_in | add_ovf;
`else
  assign sum     = psum_in + prod_ext;
  assign ovf_nxt = ovf_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wt       <= '0;
      act_out  <= '0;
      psum_out <= '0;
      ovf_out  <= 1'b0;
    end else begin
      if (wt_load) wt <= wt_in;
      act_out  <= act_in;
      psum_out <= sum;
      ovf_out  <= ovf_nxt;
    end
  end

endmodule

// File: rtl/ws_systolic_tile.sv
// Weight-stationary systolic matrix-vector tile: y[c] = sum_r x[r]*W[r][c], with load/drain FSM,
// input skew and output deskew. Define WS_SAT_EN for saturating accumulation and out_ovf flags.
module ws_systolic_tile
  import ws_sa_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [COLS*DATA_W-1:0] wt_row,
  input  logic                   act_valid,
  output logic                   act_ready,
  input  logic [ROWS*DATA_W-1:0] act_vec,
  output logic                   out_valid,
  output logic [COLS*ACC_W-1:0]  out_vec,
  output logic [COLS-1:0]        out_ovf,
  output logic                   busy
);

  localparam int unsigned LAT  = ws_latency(ROWS, COLS);
  localparam int unsigned VP_W = LAT + 1;
  localparam int unsigned IF_W = $clog2(LAT + 2);
  localparam int unsigned RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  ws_state_t        state;
  logic [RC_W-1:0]  row_cnt;
  logic [IF_W-1:0]  inflight;
  logic [IF_W-1:0]  inflight_nxt;
  logic [VP_W-1:0]  vld_pipe;
  logic             wt_fire;
  logic             act_fire;
  logic [ROWS-1:0]  wt_we;

  logic [DATA_W-1:0] act_x  [ROWS];
  logic [DATA_W-1:0] act_h  [ROWS][COLS+1];
  logic [ACC_W-1:0]  psum_v [ROWS+1][COLS];
  logic              ovf_v  [ROWS+1][COLS];

  // Handshake decode; weights take priority over activations in READY.
  assign wt_ready  = (state == ST_EMPTY) || (state == ST_LOAD) ||
                     ((state == ST_READY) && (inflight == '0));
  assign act_ready = (state == ST_READY) && !wt_valid;
  assign wt_fire   = wt_valid && wt_ready;
  assign act_fire  = act_valid && act_ready;
  assign busy      = (state != ST_READY) || (inflight != '0);
  assign out_valid = vld_pipe[LAT];

  always_comb begin
    inflight_nxt = inflight;
    if (act_fire && !out_valid)      inflight_nxt = inflight + IF_W'(1);
    else if (!act_fire && out_valid) inflight_nxt = inflight - IF_W'(1);
  end

  // Load/drain FSM: EMPTY/READY beats start a fresh load at row 0, DRAIN waits for empty pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      row_cnt  <= '0;
      inflight <= '0;
      vld_pipe <= '0;
    end else begin
      inflight <= inflight_nxt;
      vld_pipe <= VP_W'({vld_pipe, act_fire});
      case (state)
        ST_EMPTY, ST_LOAD, ST_READY: begin
          if (wt_fire) begin
            if (row_cnt == RC_W'(ROWS - 1)) begin
              state   <= ST_READY;
              row_cnt <= '0;
            end else begin
              state   <= ST_LOAD;
              row_cnt <= row_cnt + RC_W'(1);
            end
          end else if ((state == ST_READY) && wt_valid) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0) begin
            state   <= ST_LOAD;
            row_cnt <= '0;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Row r activation enters the array r cycles late; idle cycles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    assign act_x[r] = act_fire ? act_vec[r*DATA_W +: DATA_W] : '0;
    assign wt_we[r] = wt_fire && (row_cnt == RC_W'(r));
    if (r == 0) begin : g_d0
      assign act_h[r][0] = act_x[r];
    end else begin : g_dn
      logic [DATA_W-1:0] sk [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else begin
          sk[0] <= act_x[r];
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      end
      assign act_h[r][0] = sk[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ws_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .wt_load  (wt_we[r]),
        .wt_in    (wt_row[c*DATA_W +: DATA_W]),
        .act_in   (act_h[r][c]),
        .psum_in  (psum_v[r][c]),
        .ovf_in   (ovf_v[r][c]),
        .act_out  (act_h[r][c+1]),
        .psum_out (psum_v[r+1][c]),
        .ovf_out  (ovf_v[r+1][c])
      );
    end
  end

  // Column c waits COLS-1-c cycles so all columns present together; last stage is the output reg.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int unsigned D = COLS - c;
    logic [ACC_W-1:0] dq [D];

    assign psum_v[0][c] = '0;
    assign ovf_v[0][c]  = 1'b0;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < D; i++) dq[i] <= '0;
      end else begin
        dq[0] <= psum_v[ROWS][c];
        for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
      end
    end
    assign out_vec[c*ACC_W +: ACC_W] = dq[D-1];

`ifdef WS_SAT_EN
    logic dov [D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < D; i++) dov[i] <= 1'b0;
      end else begin
        dov[0] <= ovf_v[ROWS][c];
        for (int i = 1; i < D; i++) dov[i] <= dov[i-1];
      end
    end
    assign out_ovf[c] = dov[D-1];
`else
    assign out_ovf[c] = 1'b0;
`endif
  end

endmodule
